game_ctrl: RTL

Frame-level game controller for the Bomberman top level. Consumes the per-pixel collision flags from the hit detector, which are valid only while the two sprites overlap on the current pixel. Accumulates them over one VGA frame, then at each frame boundary decides the outcome: wall block, life loss, game over or win. Drives the game-state, lives, invulnerability and movement-enable signals read by the bomber, enemy and display blocks.

---
 rtl/game_pkg.sv | 14 +
 rtl/game_ctrl_if.sv | 30 +++
 rtl/game_ctrl_frame_collision_latch.sv | 23 ++
 rtl/game_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding and counter widths for the frame-level game controller.
// Types and constants only; no logic.
package game_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        HIT_FREEZE = 3'd2,
        GAME_OVER  = 3'd3,
        WIN        = 3'd4
    } game_state_t;

    localparam int FREEZE_W = 6;
    localparam int INVULN_W = 7;
endpackage

// File: rtl/game_ctrl_if.sv
// Per-pixel collision/frame inputs and game status outputs of the controller.
// master drives the frame/collision side, slave is the controller.
interface game_ctrl_if;
    import game_pkg::*;

    logic        startOfFrame;
    logic        start_key;
    logic        collision_bomber_wall;
    logic        collision_bomber_mine;
    logic        collision_bomber_explosion;
    logic        all_enemies_dead;
    game_state_t game_state;
    logic [1:0]  lives;
    logic        play_enable;
    logic        bomber_blocked;
    logic        invulnerable;
    logic        bomber_hit;

    modport master (
        output startOfFrame, start_key, collision_bomber_wall, collision_bomber_mine,
               collision_bomber_explosion, all_enemies_dead,
        input  game_state, lives, play_enable, bomber_blocked, invulnerable, bomber_hit
    );

    modport slave (
        input  startOfFrame, start_key, collision_bomber_wall, collision_bomber_mine,
               collision_bomber_explosion, all_enemies_dead,
        output game_state, lives, play_enable, bomber_blocked, invulnerable, bomber_hit
    );
endinterface

// File: rtl/game_ctrl_frame_collision_latch.sv
// Sticky per-frame collision flag; cleared on startOfFrame.
// seen is combinational (flag OR same-cycle hit) so a pixel on the boundary cycle still counts.
module frame_collision_latch (
    input  logic clk,
    input  logic reset,
    input  logic sof,
    input  logic hit,
    output logic seen
);
    logic flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (sof) begin
            flag <= 1'b0;
        end else if (hit) begin
            flag <= 1'b1;
        end
    end

    assign seen = flag | hit;
endmodule

// File: rtl/game_ctrl.sv
// Frame-level game FSM: evaluates accumulated collisions once per frame, tracks lives/freeze/immunity.
// Outputs registered, update one cycle after the evaluating startOfFrame or start edge; no backpressure.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT        = 3,
    parameter int HIT_FREEZE_FRAMES = 30,
    parameter int INVULN_FRAMES     = 60
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);
    game_state_t         state;
    logic [1:0]          lives;
    logic [FREEZE_W-1:0] freeze_cnt;
    logic [INVULN_W-1:0] inv_cnt;
    logic                play_enable;
    logic                bomber_blocked;
    logic                invulnerable;
    logic                bomber_hit;
    logic                start_low;
    logic                start_rise;
    logic                wall_now;
    logic                dmg_now;
    logic                sof;

    assign sof = bus.startOfFrame;

    frame_collision_latch u_wall (
        .clk   (clk),
        .reset (reset),
        .sof   (sof),
        .hit   (bus.collision_bomber_wall),
        .seen  (wall_now)
    );

    frame_collision_latch u_dmg (
        .clk   (clk),
        .reset (reset),
        .sof   (sof),
        .hit   (bus.collision_bomber_mine | bus.collision_bomber_explosion),
        .seen  (dmg_now)
    );

    // start_low resets to 0 so a key already held through reset never looks like a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_low <= 1'b0;
        end else begin
            start_low <= ~bus.start_key;
        end
    end

    assign start_rise = bus.start_key & start_low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lives          <= 2'(LIVES_INIT);
            freeze_cnt     <= '0;
            inv_cnt        <= '0;
            play_enable    <= 1'b0;
            bomber_blocked <= 1'b0;
            invulnerable   <= 1'b0;
            bomber_hit     <= 1'b0;
        end else begin
            bomber_hit <= 1'b0;
            case (state)
                IDLE: begin
                    lives          <= 2'(LIVES_INIT);
                    freeze_cnt     <= '0;
                    inv_cnt        <= '0;
                    invulnerable   <= 1'b0;
                    bomber_blocked <= 1'b0;
                    if (start_rise) begin
                        state       <= PLAY;
                        play_enable <= 1'b1;
                    end
                end
                PLAY: begin
                    if (sof) begin
                        if (inv_cnt != '0) begin
                            inv_cnt <= inv_cnt - INVULN_W'(1);
                        end
                        invulnerable   <= (inv_cnt > INVULN_W'(1));
                        bomber_blocked <= wall_now;
                        if (bus.all_enemies_dead) begin
                            state          <= WIN;
                            play_enable    <= 1'b0;
                            bomber_blocked <= 1'b0;
                        end else if (dmg_now && (inv_cnt == '0)) begin
                            bomber_hit     <= 1'b1;
                            play_enable    <= 1'b0;
                            bomber_blocked <= 1'b0;
                            if (lives <= 2'd1) begin
                                lives <= 2'd0;
                                state <= GAME_OVER;
                            end else begin
                                lives      <= lives - 2'd1;
                                freeze_cnt <= FREEZE_W'(HIT_FREEZE_FRAMES);
                                state      <= HIT_FREEZE;
                            end
                        end
                    end
                end
                HIT_FREEZE: begin
                    if (sof) begin
                        if (freeze_cnt <= FREEZE_W'(1)) begin
                            freeze_cnt   <= '0;
                            inv_cnt      <= INVULN_W'(INVULN_FRAMES);
                            invulnerable <= 1'b1;
                            play_enable  <= 1'b1;
                            state        <= PLAY;
                        end else begin
                            freeze_cnt <= freeze_cnt - FREEZE_W'(1);
                        end
                    end
                end
                GAME_OVER, WIN: begin
                    if (start_rise) begin
                        state        <= IDLE;
                        lives        <= 2'(LIVES_INIT);
                        freeze_cnt   <= '0;
                        inv_cnt      <= '0;
                        invulnerable <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    play_enable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.game_state     = state;
    assign bus.lives          = lives;
    assign bus.play_enable    = play_enable;
    assign bus.bomber_blocked = bomber_blocked;
    assign bus.invulnerable   = invulnerable;
    assign bus.bomber_hit     = bomber_hit;
endmodule
